// File: rtl/chk_pkg.sv
// chk_pkg: shared state encoding and index-width helper for the store checker
package chk_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, PASS, FAIL, TIMEOUT} chk_state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/chk_entry_table.sv
// chk_entry_table: expected-store table with parallel address compare and lowest-index selection
//  we_i/idx_i/addr_i/data_i   config write of one entry (sets valid)
//  clr_match_i                clear all matched bits
//  mark_i                     set matched bit of the selected entry
//  snoop_addr_i/snoop_data_i  store under test
//  sel_any_o/sel_idx_o        entry selected for checking (ordered: head entry, else lowest unmatched hit)
//  sel_ok_o                   selected entry's data equals snooped data
//  stale_bad_o                unordered only: store hits a matched entry with different data
//  empty_o                    no valid unmatched entries remain
//  last_o                     selected entry is the only one still pending
module chk_entry_table #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NCHK = 4,
  parameter int ORDERED = 1,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic          clr_match_i,
  input  logic          mark_i,
  input  logic [AW-1:0] snoop_addr_i,
  input  logic [DW-1:0] snoop_data_i,
  output logic          sel_any_o,
  output logic [IW-1:0] sel_idx_o,
  output logic          sel_ok_o,
  output logic          stale_bad_o,
  output logic          empty_o,
  output logic          last_o
);
  logic [NCHK-1:0] valid_q, matched_q, hit, pend, dm;
  logic [AW-1:0] addr_q [NCHK];
  logic [DW-1:0] data_q [NCHK];
  logic [IW-1:0] ptr, low;
  always_comb begin
    hit = '0;
    dm = '0;
    ptr = '0;
    low = '0;
    pend = valid_q & ~matched_q;
    // descending scan leaves the lowest qualifying index in ptr/low
    for (int i = NCHK - 1; i >= 0; i--) begin
      hit[i] = valid_q[i] && addr_q[i] == snoop_addr_i;
      dm[i] = data_q[i] == snoop_data_i;
      if (pend[i]) ptr = IW'(i);
      if (pend[i] && hit[i]) low = IW'(i);
    end
    sel_any_o = ORDERED != 0 ? pend[ptr] && hit[ptr] : |(pend & hit);
    sel_idx_o = ORDERED != 0 ? ptr : low;
    sel_ok_o = dm[sel_idx_o];
    stale_bad_o = ORDERED == 0 && |(hit & matched_q & ~dm);
    empty_o = pend == '0;
    last_o = (pend & ~(NCHK'(1) << sel_idx_o)) == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      matched_q <= '0;
      for (int i = 0; i < NCHK; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (we_i) begin
        valid_q[idx_i] <= 1'b1;
        addr_q[idx_i] <= addr_i;
        data_q[idx_i] <= data_i;
      end
      if (clr_match_i) matched_q <= '0;
      else if (mark_i) matched_q[sel_idx_o] <= 1'b1;
    end
  end
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: snoops data-memory stores and checks them against a loaded expected-store table
//  clk/rst_n                      clock, async active-low reset
//  cfg_we_i/cfg_idx_i/cfg_addr_i/cfg_data_i   table load (IDLE only)
//  start_i/clear_i                arm the check / return to IDLE keeping the table
//  memwrite_i/dataadr_i/writedata_i           snooped store port
//  done_o/pass_o/fail_o/timeout_o outcome flags
//  err_addr_o/err_data_o          first mismatching store
//  match_cnt_o/wr_cnt_o           entries satisfied / stores seen while armed
//  trace_vld_o/trace_data_o       echo of armed stores to TRACE_A
module mem_write_checker import chk_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NCHK = 4,
  parameter int ORDERED = 1,
  parameter int TIMEOUT = 4096,
  parameter int unsigned TRACE_A = 80,
  localparam int IW = clog2_min1(NCHK)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we_i,
  input  logic [IW-1:0] cfg_idx_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [DW-1:0] cfg_data_i,
  input  logic          start_i,
  input  logic          clear_i,
  input  logic          memwrite_i,
  input  logic [AW-1:0] dataadr_i,
  input  logic [DW-1:0] writedata_i,
  output logic          done_o,
  output logic          pass_o,
  output logic          fail_o,
  output logic          timeout_o,
  output logic [AW-1:0] err_addr_o,
  output logic [DW-1:0] err_data_o,
  output logic [IW:0]   match_cnt_o,
  output logic [15:0]   wr_cnt_o,
  output logic          trace_vld_o,
  output logic [DW-1:0] trace_data_o
);
  chk_state_t state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [IW:0] match_cnt_q, match_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [DW-1:0] err_data_q, err_data_d, trace_data_q, trace_data_d;
  logic trace_vld_q, trace_vld_d;
  logic store, bad, mark, arm, sel_any, sel_ok, stale_bad, empty, last;
  logic [IW-1:0] sel_idx;
  chk_entry_table #(.AW(AW), .DW(DW), .NCHK(NCHK), .ORDERED(ORDERED), .IW(IW)) u_tbl (
    .clk(clk),
    .rst_n(rst_n),
    .we_i(cfg_we_i && state_q == IDLE),
    .idx_i(cfg_idx_i),
    .addr_i(cfg_addr_i),
    .data_i(cfg_data_i),
    .clr_match_i(clear_i || arm),
    .mark_i(mark),
    .snoop_addr_i(dataadr_i),
    .snoop_data_i(writedata_i),
    .sel_any_o(sel_any),
    .sel_idx_o(sel_idx),
    .sel_ok_o(sel_ok),
    .stale_bad_o(stale_bad),
    .empty_o(empty),
    .last_o(last)
  );
  always_comb begin
    store = memwrite_i && state_q == ARMED;
    bad = sel_any ? !sel_ok : stale_bad;
    mark = store && sel_any && sel_ok && !clear_i;
    arm = state_q == IDLE && start_i && !clear_i;
    state_d = state_q;
    timer_d = timer_q;
    match_cnt_d = match_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    trace_vld_d = store && dataadr_i == AW'(TRACE_A) && !clear_i;
    trace_data_d = trace_vld_d ? writedata_i : trace_data_q;
    if (clear_i || arm) begin
      state_d = clear_i ? IDLE : ARMED;
      timer_d = '0;
      match_cnt_d = '0;
      wr_cnt_d = '0;
      err_addr_d = '0;
      err_data_d = '0;
      trace_data_d = clear_i ? '0 : trace_data_q;
    end else if (state_q == ARMED) begin
      timer_d = timer_q + 32'd1;
      match_cnt_d = match_cnt_q + (IW+1)'(mark);
      wr_cnt_d = store && wr_cnt_q != 16'hFFFF ? wr_cnt_q + 16'd1 : wr_cnt_q;
      // priority: FAIL over PASS over timer expiry
      if (store && bad) begin
        state_d = FAIL;
        err_addr_d = dataadr_i;
        err_data_d = writedata_i;
      end else if (empty || (mark && last)) state_d = PASS;
      else if (TIMEOUT != 0 && timer_d == 32'(TIMEOUT)) state_d = chk_pkg::TIMEOUT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      match_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      trace_vld_q <= 1'b0;
      trace_data_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      match_cnt_q <= match_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      trace_vld_q <= trace_vld_d;
      trace_data_q <= trace_data_d;
    end
  end
  assign pass_o = state_q == PASS;
  assign fail_o = state_q == FAIL;
  assign timeout_o = state_q == chk_pkg::TIMEOUT;
  assign done_o = pass_o || fail_o || timeout_o;
  assign err_addr_o = err_addr_q;
  assign err_data_o = err_data_q;
  assign match_cnt_o = match_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
  assign trace_vld_o = trace_vld_q;
  assign trace_data_o = trace_data_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed bench driving an ordered and an unordered checker with shared stimulus
module tb_mem_write_checker;
  logic clk = 1'b0;
  logic rst_n, cfg_we, start, clear, memwrite;
  logic [1:0] cfg_idx;
  logic [31:0] cfg_addr, cfg_data, dataadr, writedata;
  logic a_done, a_pass, a_fail, a_to, a_tv, b_done, b_pass, b_fail, b_to, b_tv;
  logic [31:0] a_ea, a_ed, a_td, b_ea, b_ed, b_td;
  logic [2:0] a_mc, b_mc;
  logic [15:0] a_wc, b_wc;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mem_write_checker #(.ORDERED(1)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .start_i(start), .clear_i(clear), .memwrite_i(memwrite),
    .dataadr_i(dataadr), .writedata_i(writedata), .done_o(a_done), .pass_o(a_pass),
    .fail_o(a_fail), .timeout_o(a_to), .err_addr_o(a_ea), .err_data_o(a_ed),
    .match_cnt_o(a_mc), .wr_cnt_o(a_wc), .trace_vld_o(a_tv), .trace_data_o(a_td)
  );
  mem_write_checker #(.ORDERED(0), .TIMEOUT(16)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .start_i(start), .clear_i(clear), .memwrite_i(memwrite),
    .dataadr_i(dataadr), .writedata_i(writedata), .done_o(b_done), .pass_o(b_pass),
    .fail_o(b_fail), .timeout_o(b_to), .err_addr_o(b_ea), .err_data_o(b_ed),
    .match_cnt_o(b_mc), .wr_cnt_o(b_wc), .trace_vld_o(b_tv), .trace_data_o(b_td)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  initial begin
    logic [31:0] fib [10];
    fib = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    rst_n = 1'b0; cfg_we = 1'b0; start = 1'b0; clear = 1'b0; memwrite = 1'b0;
    cfg_idx = '0; cfg_addr = '0; cfg_data = '0; dataadr = '0; writedata = '0;
    repeat (2) tick();
    chk("rst_done_a", a_done, 0);
    chk("rst_mc_a", a_mc, 0);
    chk("rst_wc_b", b_wc, 0);
    chk("rst_tv_a", a_tv, 0);
    rst_n = 1'b1;
    tick();
    // Fibonacci program: single expected store (84,34)
    cfg(2'd0, 32'd84, 32'd34);
    pulse_start();
    chk("t1_armed_done_a", a_done, 0);
    for (int k = 0; k < 10; k++) begin
      st(32'd48 + 32'(4 * k), fib[k]);
      if (k == 8) begin
        chk("t1_trace_vld", a_tv, 1);
        chk("t1_trace_data", a_td, 21);
        chk("t1_not_yet_pass", a_pass, 0);
      end
    end
    chk("t1_pass_a", a_pass, 1);
    chk("t1_pass_b", b_pass, 1);
    chk("t1_mc_a", a_mc, 1);
    chk("t1_wc_a", a_wc, 10);
    chk("t1_trace_drop", a_tv, 0);
    chk("t1_trace_hold", a_td, 21);
    pulse_clear();
    chk("t1_clr_done", a_done, 0);
    chk("t1_clr_mc", a_mc, 0);
    chk("t1_clr_wc", a_wc, 0);
    chk("t1_clr_td", a_td, 0);
    // Bad data: ordered ignores store to a non-head entry, unordered fails
    cfg(2'd0, 32'd80, 32'd21);
    cfg(2'd1, 32'd84, 32'd34);
    pulse_start();
    st(32'd84, 32'd33);
    chk("t2_fail_a", a_fail, 0);
    chk("t2_fail_b", b_fail, 1);
    chk("t2_ea_b", b_ea, 84);
    chk("t2_ed_b", b_ed, 33);
    st(32'd80, 32'd21);
    chk("t2_mc_a", a_mc, 1);
    st(32'd84, 32'd33);
    chk("t2_fail_a2", a_fail, 1);
    chk("t2_ea_a", a_ea, 84);
    chk("t2_ed_a", a_ed, 33);
    chk("t2_frozen_mc_b", b_mc, 0);
    chk("t2_frozen_wc_b", b_wc, 1);
    chk("t2_frozen_mc_a", a_mc, 1);
    pulse_clear();
    // Ordering: {(8,1),(12,2)} with stores 12,8,12
    cfg(2'd0, 32'd8, 32'd1);
    cfg(2'd1, 32'd12, 32'd2);
    pulse_start();
    st(32'd12, 32'd2);
    chk("t3_mc_a0", a_mc, 0);
    chk("t4_mc_b1", b_mc, 1);
    st(32'd8, 32'd1);
    chk("t3_mc_a1", a_mc, 1);
    chk("t3_pass_a_early", a_pass, 0);
    chk("t4_pass_b", b_pass, 1);
    chk("t4_mc_b2", b_mc, 2);
    st(32'd12, 32'd2);
    chk("t3_pass_a", a_pass, 1);
    chk("t3_mc_a2", a_mc, 2);
    chk("t3_wc_a", a_wc, 3);
    chk("t4_wc_b_frozen", b_wc, 2);
    chk("t4_fail_b", b_fail, 0);
    pulse_clear();
    // Timeout after 16 armed cycles on the TIMEOUT=16 instance
    pulse_start();
    repeat (15) tick();
    chk("t5_to_b_early", b_to, 0);
    tick();
    chk("t5_to_b", b_to, 1);
    chk("t5_done_b", b_done, 1);
    chk("t5_to_a", a_to, 0);
    chk("t5_done_a", a_done, 0);
    pulse_clear();
    chk("t5_clr_to_b", b_to, 0);
    chk("t5_clr_done_b", b_done, 0);
    // Async reset mid-ARMED wipes counters and table
    pulse_start();
    st(32'd8, 32'd1);
    chk("t6_mc_a_pre", a_mc, 1);
    chk("t6_mc_b_pre", b_mc, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mc_a", a_mc, 0);
    chk("t6_rst_mc_b", b_mc, 0);
    chk("t6_rst_wc_a", a_wc, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    chk("t6_armed_pass_a", a_pass, 0);
    tick();
    chk("t6_empty_pass_a", a_pass, 1);
    chk("t6_empty_pass_b", b_pass, 1);
    pulse_clear();
    // clear and start together: clear wins, stays IDLE
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    repeat (2) tick();
    chk("t7_clear_wins_a", a_done, 0);
    chk("t7_clear_wins_b", b_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
